// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO drained by a bit-timing FSM.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic        SelIO,
    output logic [31:0] ReadDataIO,
    output logic        tx,
    output logic        Busy
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int                CNT_FW   = $clog2(FIFO_DEPTH) + 1;

    logic              sel_tx;
    logic              sel_st;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              ovf_set;
    logic              ovf_clr;
    logic              clk_last;
    logic              nonempty_nxt;
    logic              active_nxt;
    logic [7:0]        fifo_rdata;
    logic [CNT_FW-1:0] fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    uart_state_t       state;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              overflow;
    logic              unused_wdata;

    assign unused_wdata = ^WriteDataM[31:8];

    assign sel_tx = DataAdrM == BASE_ADDR + TXDATA_OFS;
    assign sel_st = DataAdrM == BASE_ADDR + STATUS_OFS;
    assign SelIO  = sel_tx || sel_st;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ReadDataIO = '0;
        if (sel_st) begin
            ReadDataIO[ST_OVF]   = overflow;
            ReadDataIO[ST_EMPTY] = fifo_empty;
            ReadDataIO[ST_FULL]  = fifo_full;
            ReadDataIO[ST_BUSY]  = Busy;
        end
    end

    assign push_req = MemWriteM && sel_tx;
    assign ovf_clr  = MemWriteM && sel_st && WriteDataM[ST_OVF];
    assign pop      = (state == IDLE) && !fifo_empty;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && fifo_full && !pop;
    assign clk_last = clk_cnt == CLK_LAST;

    // Busy is registered from next-state values so it moves on the same edge as FIFO and FSM.
    assign nonempty_nxt = push_ok || (fifo_count > CNT_FW'(pop));
    assign active_nxt   = (state == IDLE) ? pop : !((state == STOP) && clk_last);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (WriteDataM[7:0]),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
            tx       <= 1'b1;
            Busy     <= 1'b0;
        end else begin
            Busy <= active_nxt || nonempty_nxt;

            if (ovf_clr)
                overflow <= 1'b0;
            else if (ovf_set)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= fifo_rdata;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // tx follows the bit that becomes shift[0] after this shift.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
